// File: rtl/hamming_tx_if.sv
// ---------------------------------------------------------------------------
// hamming_tx_if
//   Nibble input handshake of the Hamming(7,4) transmitter.
//   Signals:
//     in_data   [3:0]  nibble to encode (d0 = in_data[0] .. d3 = in_data[3])
//     in_valid         in_data is valid
//     in_ready         receiver can accept; a transfer happens on a rising
//                      clock edge with in_valid & in_ready both high
//   Modports:
//     master  - nibble source (drives in_data / in_valid)
//     slave   - the transmitter (drives in_ready)
// ---------------------------------------------------------------------------
interface hamming_tx_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/hamming_tx.sv
// ---------------------------------------------------------------------------
// hamming_tx
//   Hamming(7,4) transmit path. Nibbles arriving on the in_if handshake are
//   encoded to cw = {d3,d2,d1,p4,d0,p2,p1} and written into a small FIFO.
//   A framer pops one codeword at a time and sends it on a one-wire line:
//   start bit (0), seven code bits LSB-first, stop bit (1), each bit held
//   CLKS_PER_BIT cycles. One code bit of a frame can be flipped at load time
//   to exercise the downstream corrector.
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous reset, active-high
//     in_if       slave nibble handshake (in_data, in_valid, in_ready)
//     inj_en      in   flip one code bit of the frame being loaded
//     inj_pos     in   bit to flip (0..6); 7 = no flip
//     ser_out     out  serial line, idles high
//     cw_out      out  codeword of the current frame (after injection)
//     cw_valid    out  one-cycle pulse when cw_out is loaded
//     busy        out  frame in progress
//     fifo_count  out  FIFO occupancy
// ---------------------------------------------------------------------------
module hamming_tx #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    hamming_tx_if.slave                 in_if,
    input  logic                        inj_en,
    input  logic [2:0]                  inj_pos,
    output logic                        ser_out,
    output logic [6:0]                  cw_out,
    output logic                        cw_valid,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [PW-1:0]   PER_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL     = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Codeword FIFO
    logic [6:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;

    // Framer
    state_t          state_q;
    logic [2:0]      bit_q;
    logic [PW-1:0]   per_q;
    logic            ser_q;
    logic [6:0]      cw_q;
    logic            cw_valid_q;

    logic            push, pop, per_last;
    logic [6:0]      head, inj_mask;

    assign in_if.in_ready = (count_q != FULL);
    assign push           = in_if.in_valid && in_if.in_ready;
    assign per_last       = (per_q == PER_LAST);

    // A frame loads from IDLE, or on the last STOP cycle so consecutive
    // frames run without an idle gap.
    assign pop      = (count_q != '0) &&
                      ((state_q == IDLE) || ((state_q == STOP) && per_last));
    assign head     = mem_q[rd_ptr_q];
    assign inj_mask = (inj_en && (inj_pos != 3'd7)) ? (7'd1 << inj_pos) : 7'd0;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= encode(in_if.in_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            per_q      <= '0;
            ser_q      <= 1'b1;
            cw_q       <= '0;
            cw_valid_q <= 1'b0;
        end else begin
            cw_valid_q <= 1'b0;
            if (pop) begin
                state_q    <= START;
                bit_q      <= '0;
                per_q      <= '0;
                ser_q      <= 1'b0;
                cw_q       <= head ^ inj_mask;
                cw_valid_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        ser_q <= 1'b1;
                    end
                    START: begin
                        if (per_last) begin
                            per_q   <= '0;
                            bit_q   <= '0;
                            ser_q   <= cw_q[0];
                            state_q <= DATA;
                        end else begin
                            per_q <= per_q + PW'(1);
                        end
                    end
                    DATA: begin
                        if (per_last) begin
                            per_q <= '0;
                            if (bit_q == 3'd6) begin
                                ser_q   <= 1'b1;
                                state_q <= STOP;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                ser_q <= cw_q[bit_q + 3'd1];
                            end
                        end else begin
                            per_q <= per_q + PW'(1);
                        end
                    end
                    STOP: begin
                        if (per_last) begin
                            per_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            per_q <= per_q + PW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        ser_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ser_out    = ser_q;
    assign cw_out     = cw_q;
    assign cw_valid   = cw_valid_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;

endmodule
